// File: rtl/lcg_sequencer.sv
// LCG PRNG control stage: drives a handshake multiplier, forms x' = (A*x + C) mod 2^WIDTH
// and offers each new word on a valid/ready output register.
module lcg_sequencer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MULT_A   = 5,
  parameter int unsigned INC_C    = 3,
  parameter int unsigned SEED_RST = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed_value,
  input  logic               run,
  output logic [WIDTH-1:0]   rnd_data,
  output logic               rnd_valid,
  input  logic               rnd_ready,
  output logic               busy,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_enable,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] x, x_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             valid_nxt;
  logic             enable_nxt;
  logic [WIDTH-1:0] lcg_nxt;
  logic             unused_hi;

  // Only the low half of the product matters; the add wraps at WIDTH bits.
  assign lcg_nxt   = mul_result[WIDTH-1:0] + WIDTH'(INC_C);
  assign unused_hi = ^mul_result[2*WIDTH-1:WIDTH];

  assign mul_a = x;
  assign mul_b = WIDTH'(MULT_A);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      x          <= WIDTH'(SEED_RST);
      rnd_data   <= '0;
      rnd_valid  <= 1'b0;
      mul_enable <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      x          <= x_nxt;
      rnd_data   <= data_nxt;
      rnd_valid  <= valid_nxt;
      mul_enable <= enable_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!seed_load && run && !rnd_valid) state_nxt = REQ;
      end
      REQ: begin
        if (mul_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!mul_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and x
  always_comb begin
    x_nxt      = x;
    data_nxt   = rnd_data;
    valid_nxt  = rnd_valid & ~rnd_ready;
    enable_nxt = mul_enable;
    case (state)
      IDLE: begin
        if (seed_load) begin
          x_nxt = seed_value;
        end else if (run && !rnd_valid) begin
          enable_nxt = 1'b1;
        end
      end
      REQ: begin
        // x stays put until done: the multiplier samples mul_a late.
        enable_nxt = 1'b1;
        if (mul_done) begin
          x_nxt      = lcg_nxt;
          data_nxt   = lcg_nxt;
          valid_nxt  = 1'b1;
          enable_nxt = 1'b0;
        end
      end
      DRAIN: begin
        enable_nxt = 1'b0;
      end
      default: begin
        enable_nxt = 1'b0;
      end
    endcase
  end

endmodule
